// File: rtl/ro_heater_seq.sv
// Multi-bank ring-oscillator heater sequencer: replays a latched bit pattern onto
// NUM_BANKS heater banks, holding each bit for a programmable dwell, one-shot or looped.
module ro_heater_seq #(
  parameter int NUM_BANKS      = 4,
  parameter int MAX_RO_HEATERS = 16,
  parameter int MAX_BIT_SIZE   = 256,
  parameter int CYC_W          = 32,
  parameter int LEN_W          = $clog2(MAX_BIT_SIZE + 1),
  parameter int ON_W           = $clog2(MAX_RO_HEATERS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ro_heater_start,
  input  logic                                ro_heater_stop,
  input  logic [MAX_BIT_SIZE-1:0]             ro_heater_data,
  input  logic [LEN_W-1:0]                    ro_heater_data_len,
  input  logic [ON_W-1:0]                     ro_heater_on_num,
  input  logic [CYC_W-1:0]                    ro_heater_dwell,
  input  logic                                ro_heater_loop,
  input  logic [NUM_BANKS-1:0]                ro_heater_bank_mask,
  output logic [NUM_BANKS*MAX_RO_HEATERS-1:0] heater_en,
  output logic                                ro_heater_busy,
  output logic                                ro_heater_done,
  output logic [LEN_W-1:0]                    ro_heater_bit_idx,
  output logic [31:0]                         ro_heater_debug
);

  localparam int HEAT_W = NUM_BANKS * MAX_RO_HEATERS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  // Latched configuration
  logic [MAX_BIT_SIZE-1:0] data_q;
  logic [LEN_W-1:0]        len_q;
  logic [ON_W-1:0]         on_q;
  logic [CYC_W-1:0]        dwell_q;
  logic                    loop_q;
  logic [NUM_BANKS-1:0]    mask_q;

  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  idx_d, idx_inc;
  logic [HEAT_W-1:0] heat_d;
  logic              busy_d, done_d, latch_cfg;
  logic [15:0]       pass_q, pass_d, bits_q, bits_d;

  logic [LEN_W-1:0]  len_in;
  logic [ON_W-1:0]   on_in;
  logic [CYC_W-1:0]  dwell_in;

  assign len_in   = (ro_heater_data_len > LEN_W'(MAX_BIT_SIZE)) ? LEN_W'(MAX_BIT_SIZE)
                                                                : ro_heater_data_len;
  assign on_in    = (ro_heater_on_num > ON_W'(MAX_RO_HEATERS)) ? ON_W'(MAX_RO_HEATERS)
                                                               : ro_heater_on_num;
  assign dwell_in = (ro_heater_dwell == '0) ? CYC_W'(1) : ro_heater_dwell;
  assign idx_inc  = ro_heater_bit_idx + LEN_W'(1);

  assign ro_heater_debug = {pass_q, bits_q};

  // Pattern bit select written as an explicit mux so the index width never has to
  // match the data width exactly.
  function automatic logic data_bit(input logic [MAX_BIT_SIZE-1:0] d,
                                    input logic [LEN_W-1:0]        idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_BIT_SIZE; i++)
      if (LEN_W'(i) == idx) r = d[i];
    return r;
  endfunction

  // Thermometer field of on_num ones for every participating bank when the bit is set.
  function automatic logic [HEAT_W-1:0] bank_pattern(input logic                 bit_val,
                                                     input logic [NUM_BANKS-1:0] mask,
                                                     input logic [ON_W-1:0]      on_num);
    logic [HEAT_W-1:0] res;
    res = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int i = 0; i < MAX_RO_HEATERS; i++)
        res[b*MAX_RO_HEATERS + i] = bit_val & mask[b] & (ON_W'(i) < on_num);
    return res;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = ro_heater_bit_idx;
    heat_d    = heater_en;
    busy_d    = ro_heater_busy;
    done_d    = 1'b0;
    pass_d    = pass_q;
    bits_d    = bits_q;
    latch_cfg = 1'b0;

    case (state_q)
      IDLE: begin
        // Stop wins over a simultaneous start.
        if (ro_heater_start && !ro_heater_stop) begin
          latch_cfg = 1'b1;
          if (len_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
            heat_d  = bank_pattern(ro_heater_data[0], ro_heater_bank_mask, on_in);
          end
        end
      end
      RUN: begin
        if (ro_heater_stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          heat_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == dwell_q - CYC_W'(1)) begin
          cnt_d  = '0;
          bits_d = bits_q + 16'd1;
          if (ro_heater_bit_idx == len_q - LEN_W'(1)) begin
            if (loop_q) begin
              idx_d  = '0;
              pass_d = pass_q + 16'd1;
              heat_d = bank_pattern(data_q[0], mask_q, on_q);
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              heat_d  = '0;
              idx_d   = '0;
            end
          end else begin
            idx_d  = idx_inc;
            heat_d = bank_pattern(data_bit(data_q, idx_inc), mask_q, on_q);
          end
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      heater_en         <= '0;
      ro_heater_busy    <= 1'b0;
      ro_heater_done    <= 1'b0;
      ro_heater_bit_idx <= '0;
      pass_q            <= '0;
      bits_q            <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      heater_en         <= heat_d;
      ro_heater_busy    <= busy_d;
      ro_heater_done    <= done_d;
      ro_heater_bit_idx <= idx_d;
      pass_q            <= pass_d;
      bits_q            <= bits_d;
    end
  end

  // NOTE: configuration registers carry no reset; they are only read in RUN, which
  // is reachable solely through a start that has just loaded them.
  always_ff @(posedge clk) begin
    if (latch_cfg) begin
      data_q  <= ro_heater_data;
      len_q   <= len_in;
      on_q    <= on_in;
      dwell_q <= dwell_in;
      loop_q  <= ro_heater_loop;
      mask_q  <= ro_heater_bank_mask;
    end
  end

endmodule

// File: tb/tb_ro_heater_seq.sv
// Self-checking bench for ro_heater_seq: directed scenarios plus random traffic, all
// compared every cycle against an elapsed-time model of the sequencer.
module tb_ro_heater_seq;

  localparam int NB    = 4;
  localparam int MH    = 16;
  localparam int MB    = 256;
  localparam int CYC_W = 32;
  localparam int LEN_W = $clog2(MB + 1);
  localparam int ON_W  = $clog2(MH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop;
  logic [MB-1:0]     data;
  logic [LEN_W-1:0]  len;
  logic [ON_W-1:0]   on_num;
  logic [CYC_W-1:0]  dwell;
  logic              loop_en;
  logic [NB-1:0]     mask;
  logic [NB*MH-1:0]  heater_en;
  logic              busy, done;
  logic [LEN_W-1:0]  bit_idx;
  logic [31:0]       debug;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  ro_heater_seq #(
    .NUM_BANKS(NB), .MAX_RO_HEATERS(MH), .MAX_BIT_SIZE(MB), .CYC_W(CYC_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ro_heater_start     (start),
    .ro_heater_stop      (stop),
    .ro_heater_data      (data),
    .ro_heater_data_len  (len),
    .ro_heater_on_num    (on_num),
    .ro_heater_dwell     (dwell),
    .ro_heater_loop      (loop_en),
    .ro_heater_bank_mask (mask),
    .heater_en           (heater_en),
    .ro_heater_busy      (busy),
    .ro_heater_done      (done),
    .ro_heater_bit_idx   (bit_idx),
    .ro_heater_debug     (debug)
  );

  always #5 clk = ~clk;

  // Reference model: a run is described by the cycles elapsed since its start edge.
  bit            m_run, m_done, m_loop;
  int            m_n, m_len, m_on, m_dwell, m_bits, m_pass;
  logic [MB-1:0] m_data;
  logic [NB-1:0] m_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int l;
    m_done = 1'b0;
    if (rst) begin
      m_run  = 1'b0;
      m_bits = 0;
      m_pass = 0;
    end else if (!m_run) begin
      if (start && !stop) begin
        l = (int'(len) > MB) ? MB : int'(len);
        if (l == 0) begin
          m_done = 1'b1;
        end else begin
          m_run   = 1'b1;
          m_n     = 0;
          m_len   = l;
          m_on    = (int'(on_num) > MH) ? MH : int'(on_num);
          m_dwell = (dwell == 0) ? 1 : int'(dwell);
          m_loop  = loop_en;
          m_data  = data;
          m_mask  = mask;
        end
      end
    end else if (stop) begin
      // The aborted (partial) bit is not counted.
      m_bits += m_n / m_dwell;
      m_pass += m_n / (m_len * m_dwell);
      m_run  = 1'b0;
      m_done = 1'b1;
    end else begin
      m_n++;
      if (!m_loop && m_n == m_len * m_dwell) begin
        m_bits += m_len;
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic [63:0] exp_heat;
    logic [16:0] field;
    int          idx, bits, pass;
    exp_heat = '0;
    idx      = 0;
    bits     = m_bits;
    pass     = m_pass;
    if (m_run) begin
      idx  = (m_n / m_dwell) % m_len;
      bits = m_bits + m_n / m_dwell;
      pass = m_pass + m_n / (m_len * m_dwell);
      field = (17'd1 << m_on) - 17'd1;
      for (int b = 0; b < NB; b++)
        if (m_mask[b] && m_data[idx]) exp_heat[b*MH +: MH] = field[MH-1:0];
    end
    check("heater_en", heater_en, exp_heat);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("bit_idx", bit_idx, idx);
    check("debug", debug, {pass[15:0], bits[15:0]});
    if (done) done_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic cfg(input logic [MB-1:0] d, input int l, input int on, input int dw,
                     input bit lp, input logic [NB-1:0] mk);
    data    = d;
    len     = LEN_W'(l);
    on_num  = ON_W'(on);
    dwell   = CYC_W'(dw);
    loop_en = lp;
    mask    = mk;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [15:0] t1_seq [8] = '{16'h0, 16'h1F, 16'h0, 16'h1F, 16'h0, 16'h1F, 16'h0, 16'h1F};

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg('0, 0, 0, 0, 1'b0, '0);
    m_run = 1'b0; m_n = 0; m_bits = 0; m_pass = 0; m_done = 1'b0;
    m_len = 1; m_dwell = 1; m_on = 0; m_loop = 1'b0; m_data = '0; m_mask = '0;
    tick(); tick();
    check("reset_heater", heater_en, 64'h0);
    check("reset_debug", debug, 32'h0);
    rst = 1'b0;
    tick();

    // One-shot, alternating pattern
    cfg(MB'(170), 8, 5, 1, 1'b0, 4'b1111);
    d0 = done_seen;
    pulse_start();
    check("t1_bank0_0", heater_en[15:0], t1_seq[0]);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t1_bank3_seq", heater_en[63:48], t1_seq[i]);
    end
    tick();
    check("t1_done", done, 1'b1);
    check("t1_busy_end", busy, 1'b0);
    tick(); tick();
    check("t1_done_once", done_seen - d0, 1);
    check("t1_debug", debug, 32'h0000_0008);

    // Dwell + mask + on_num clamp
    cfg(MB'(3), 2, 20, 3, 1'b0, 4'b0101);
    pulse_start();
    for (int i = 1; i < 6; i++) begin
      check("t2_heat", heater_en, 64'h0000_FFFF_0000_FFFF);
      tick();
    end
    check("t2_heat_last", heater_en, 64'h0000_FFFF_0000_FFFF);
    tick();
    check("t2_done", done, 1'b1);
    tick();

    // Loop + abort from a clean reset
    rst = 1'b1; tick(); rst = 1'b0; tick();
    cfg(MB'(1), 1, 4, 2, 1'b1, 4'b1111);
    pulse_start();
    repeat (6) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("t3_heat_clear", heater_en, 64'h0);
    check("t3_done", done, 1'b1);
    check("t3_debug", debug, {16'd3, 16'd3});
    tick();

    // len == 0: done pulse only
    cfg(MB'(5), 0, 3, 1, 1'b0, 4'b1111);
    pulse_start();
    check("t4_len0_done", done, 1'b1);
    check("t4_len0_busy", busy, 1'b0);
    tick();
    // start + stop together in IDLE
    cfg(MB'(5), 3, 3, 1, 1'b0, 4'b1111);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("t4_ss_busy", busy, 1'b0);
    check("t4_ss_done", done, 1'b0);
    tick();
    // start during RUN is ignored
    cfg(MB'(170), 8, 5, 1, 1'b0, 4'b1111);
    pulse_start();
    tick();
    cfg({MB{1'b1}}, 3, 16, 2, 1'b1, 4'b0011);
    pulse_start();
    repeat (8) tick();
    check("t4_rerun_idle", busy, 1'b0);

    // Reset mid-run at bit 3, then replay from bit 0
    cfg(MB'(170), 8, 5, 1, 1'b0, 4'b1111);
    pulse_start();
    repeat (3) tick();
    check("t5_at_bit3", bit_idx, 9'd3);
    d0 = done_seen;
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_heater", heater_en, 64'h0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_debug", debug, 32'h0);
    pulse_start();
    check("t5_replay_idx", bit_idx, 9'd0);
    check("t5_no_done", done_seen - d0, 0);
    repeat (10) tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      for (int w = 0; w < MB / 32; w++) data[w*32 +: 32] = $urandom();
      r = $urandom_range(0, 9);
      len     = (r == 0) ? '0 : (r < 8) ? LEN_W'($urandom_range(1, 10))
                                        : LEN_W'($urandom_range(250, 300));
      on_num  = ON_W'($urandom_range(0, 31));
      dwell   = CYC_W'($urandom_range(0, 3));
      loop_en = $urandom_range(0, 1);
      mask    = NB'($urandom());
      tick();
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
